// File: rtl/xc_malu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : xc_malu_arbiter
//  Purpose  : Round-robin sharing of one multi-cycle xc_malu between two
//             requesters, with response channel, watchdog and illegal-op
//             rejection.
//  Revision : 1.0  initial release
// ============================================================================
module xc_malu_arbiter #(
  parameter int TIMEOUT = 80,  // max BUSY cycles before abort (>= 2)
  parameter int CW      = 7    // watchdog width, 2**CW > TIMEOUT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [2:0]  req0_pw,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic [31:0] req0_rs3,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [2:0]  req1_pw,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic [31:0] req1_rs3,
  input  logic        ctrl_flush,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  output logic [13:0] malu_uop,
  output logic [4:0]  malu_pw,
  output logic        malu_valid,
  output logic        malu_flush,
  input  logic [63:0] malu_result,
  input  logic        malu_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  output logic        rsp_err
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_BUSY  = 4'b0010,
    S_RESP  = 4'b0100,
    S_FLUSH = 4'b1000
  } state_t;

  localparam logic [CW-1:0] c_wd_last = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_last_grant;
  logic [CW-1:0] r_wd;

  logic          w_grant_any;
  logic          w_grant_id;
  logic [3:0]    w_op;
  logic [2:0]    w_pw;
  logic          w_legal;
  logic [13:0]   w_uop;
  logic [4:0]    w_pw_oh;
  logic          w_timeout;

  // Arbitration and decode of the selected request; ready only in an unflushed IDLE.
  always_comb begin
    w_grant_any = (r_state == S_IDLE) && !ctrl_flush && (req0_valid || req1_valid);
    // On a tie the requester that did not win last time gets the ALU.
    w_grant_id  = (req0_valid && req1_valid) ? !r_last_grant : req1_valid;
    req0_ready  = w_grant_any && !w_grant_id;
    req1_ready  = w_grant_any &&  w_grant_id;
    w_op        = w_grant_id ? req1_op : req0_op;
    w_pw        = w_grant_id ? req1_pw : req0_pw;
    w_legal     = (w_op < 4'd14) && (w_pw < 3'd5);
    w_uop       = (w_op < 4'd14) ? (14'd1 << w_op) : 14'd0;
    w_pw_oh     = (w_pw < 3'd5)  ? (5'd1 << w_pw)  : 5'd0;
    w_timeout   = (r_wd == c_wd_last);
  end

  // Next-state logic; ctrl_flush overrides everything once an op is in flight.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_any) w_next = w_legal ? S_BUSY : S_RESP;
      S_BUSY:  if (ctrl_flush) w_next = S_FLUSH;
               else if (malu_ready || w_timeout) w_next = S_RESP;
      S_RESP:  if (ctrl_flush || rsp_ready) w_next = S_FLUSH;
      S_FLUSH: w_next = ctrl_flush ? S_FLUSH : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Datapath: operand latch on grant, result capture in BUSY, registered handshakes.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_last_grant <= 1'b1;
      r_wd         <= '0;
      malu_rs1     <= '0;
      malu_rs2     <= '0;
      malu_rs3     <= '0;
      malu_uop     <= '0;
      malu_pw      <= '0;
      malu_valid   <= 1'b0;
      malu_flush   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_err      <= 1'b0;
    end else begin
      malu_valid <= (w_next == S_BUSY);
      malu_flush <= (w_next == S_FLUSH);
      rsp_valid  <= (w_next == S_RESP);
      if (w_grant_any) begin
        malu_rs1     <= w_grant_id ? req1_rs1 : req0_rs1;
        malu_rs2     <= w_grant_id ? req1_rs2 : req0_rs2;
        malu_rs3     <= w_grant_id ? req1_rs3 : req0_rs3;
        // An illegal request must leave the ALU untouched.
        malu_uop     <= w_legal ? w_uop : 14'd0;
        malu_pw      <= w_pw_oh;
        rsp_id       <= w_grant_id;
        r_last_grant <= w_grant_id;
        r_wd         <= '0;
        if (!w_legal) begin
          rsp_result <= '0;
          rsp_err    <= 1'b1;
        end
      end else if (r_state == S_BUSY) begin
        r_wd <= r_wd + 1'b1;
        if (!ctrl_flush) begin
          // ALU completion beats a simultaneous watchdog expiry.
          if (malu_ready) begin
            rsp_result <= malu_result;
            rsp_err    <= 1'b0;
          end else if (w_timeout) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xc_malu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xc_malu_arbiter
//  Purpose  : Self-checking bench for xc_malu_arbiter with a transaction-level
//             reference model and a behavioural ALU responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xc_malu_arbiter;

  localparam int TO = 80;
  localparam int CW = 7;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = 0, req1_op = 0;
  logic [2:0]  req0_pw = 0, req1_pw = 0;
  logic [31:0] req0_rs1 = 0, req0_rs2 = 0, req0_rs3 = 0;
  logic [31:0] req1_rs1 = 0, req1_rs2 = 0, req1_rs3 = 0;
  logic        ctrl_flush = 0;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic        malu_valid, malu_flush;
  logic [63:0] malu_result = 0;
  logic        malu_ready = 0;
  logic        rsp_valid;
  logic        rsp_ready = 0;
  logic        rsp_id;
  logic [63:0] rsp_result;
  logic        rsp_err;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_grant_cyc = -1;
  bit m_last   = 1'b1;  // model of who won the previous grant

  xc_malu_arbiter #(.TIMEOUT(TO), .CW(CW)) dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_pw(req0_pw),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_rs3(req0_rs3),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_pw(req1_pw),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_rs3(req1_rs3),
    .ctrl_flush(ctrl_flush),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_uop(malu_uop), .malu_pw(malu_pw), .malu_valid(malu_valid), .malu_flush(malu_flush),
    .malu_result(malu_result), .malu_ready(malu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Settle point a little after the falling edge: inputs driven here, outputs sampled here.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // One full transaction from an IDLE cycle through the FLUSH pulse.
  // alu_lat = BUSY cycle (1-based) in which the ALU answers; 0 = never.
  task automatic transact(input bit v0, input bit v1, input int alu_lat, input int rsp_hold,
                          input logic [63:0] res, input bit chk_spacing);
    bit          id, legal, ok;
    logic [3:0]  op;
    logic [2:0]  pw;
    logic [31:0] a, b, c;
    logic [63:0] exp_res;
    bit          exp_err;
    int          busy, exp_busy;
    id    = (v0 && v1) ? !m_last : v1;
    m_last = id;
    op    = id ? req1_op : req0_op;
    pw    = id ? req1_pw : req0_pw;
    a     = id ? req1_rs1 : req0_rs1;
    b     = id ? req1_rs2 : req0_rs2;
    c     = id ? req1_rs3 : req0_rs3;
    legal = (op <= 13) && (pw <= 4);
    ok    = (alu_lat >= 1) && (alu_lat <= TO);
    tick();
    req0_valid = v0;
    req1_valid = v1;
    #1;
    check("idle_no_flush", {63'd0, malu_flush}, 0);
    check("req0_ready_grant", {63'd0, req0_ready}, {63'd0, !id});
    check("req1_ready_grant", {63'd0, req1_ready}, {63'd0, id});
    if (chk_spacing) check("req_to_req_cycles", cyc - last_grant_cyc, 4);
    last_grant_cyc = cyc;
    busy = 0;
    tick();
    if (legal) begin
      exp_busy = ok ? alu_lat : TO;
      exp_res  = ok ? res : 64'd0;
      exp_err  = !ok;
      while (malu_valid === 1'b1 && busy < TO + 4) begin
        busy++;
        if (busy == 1 || busy == exp_busy) begin
          check("malu_uop", malu_uop, 64'd1 << op);
          check("malu_pw", malu_pw, 64'd1 << pw);
          check("malu_rs1", malu_rs1, a);
          check("malu_rs2", malu_rs2, b);
          check("malu_rs3", malu_rs3, c);
          check("busy_no_ready", {62'd0, req1_ready, req0_ready}, 0);
          check("busy_no_rsp", {63'd0, rsp_valid}, 0);
        end
        // Operand inputs may change freely once granted.
        req0_rs1 = $urandom;
        req1_rs1 = $urandom;
        malu_ready  = (busy == alu_lat);
        malu_result = (busy == alu_lat) ? res : {$urandom, $urandom};
        tick();
      end
      malu_ready = 1'b0;
      check("busy_cycles", busy, exp_busy);
    end else begin
      exp_res = 64'd0;
      exp_err = 1'b1;
      check("illegal_uop_zero", malu_uop, 0);
    end
    for (int h = 0; h <= rsp_hold; h++) begin
      check("rsp_valid", {63'd0, rsp_valid}, 1);
      check("rsp_id", {63'd0, rsp_id}, {63'd0, id});
      check("rsp_result", rsp_result, exp_res);
      check("rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
      check("resp_malu_idle", {62'd0, malu_valid, malu_flush}, 0);
      check("resp_no_ready", {62'd0, req1_ready, req0_ready}, 0);
      rsp_ready = (h == rsp_hold);
      tick();
    end
    rsp_ready = 1'b0;
    check("flush_pulse", {63'd0, malu_flush}, 1);
    check("flush_no_rsp", {62'd0, rsp_valid, malu_valid}, 0);
  endtask

  initial begin
    bit v0, v1;
    int lat, hold;
    // Reset
    repeat (3) tick();
    check("rst_malu_valid", {63'd0, malu_valid}, 0);
    check("rst_malu_flush", {63'd0, malu_flush}, 0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_err", {63'd0, rsp_err}, 0);
    check("rst_malu_uop", malu_uop, 0);
    resetn = 1'b1;
    tick();

    // req0 mul 7*6, ALU answers in its 33rd cycle with 42
    req0_op = 4'd4; req0_pw = 3'd0; req0_rs1 = 32'd7; req0_rs2 = 32'd6; req0_rs3 = 32'd0;
    transact(1, 0, 33, 0, 64'd42, 0);
    req0_valid = 0;

    // req1 illegal op -> error response without touching the ALU
    req1_op = 4'd15; req1_pw = 3'd0; req1_rs1 = $urandom; req1_rs2 = $urandom; req1_rs3 = $urandom;
    transact(0, 1, 1, 1, 64'd0, 0);
    req1_valid = 0;

    // Both requesting continuously: strict alternation at minimum spacing
    for (int i = 0; i < 4; i++) begin
      req0_op = 4'($urandom_range(0, 13)); req0_pw = 3'($urandom_range(0, 4));
      req1_op = 4'($urandom_range(0, 13)); req1_pw = 3'($urandom_range(0, 4));
      req0_rs2 = $urandom; req1_rs2 = $urandom; req0_rs3 = $urandom; req1_rs3 = $urandom;
      transact(1, 1, 1, 0, {$urandom, $urandom}, i > 0);
      check("alternate_id", {63'd0, rsp_id}, i % 2);
    end
    req0_valid = 0; req1_valid = 0;

    // Watchdog: ALU never answers
    req0_op = 4'd0; req0_pw = 3'd1;
    transact(1, 0, 0, 1, 64'd0, 0);
    req0_valid = 0;

    // Response back-pressure for 10 cycles
    req1_op = 4'd13; req1_pw = 3'd2;
    transact(0, 1, 3, 10, 64'hDEAD_BEEF_0123_4567, 0);
    req1_valid = 0;

    // ctrl_flush in IDLE blocks the grant
    tick();
    req0_valid = 1; ctrl_flush = 1;
    #1;
    check("idle_flush_no_ready", {63'd0, req0_ready}, 0);
    tick();
    check("idle_flush_no_busy", {62'd0, malu_valid, rsp_valid}, 0);
    req0_valid = 0; ctrl_flush = 0;

    // ctrl_flush five cycles into BUSY
    tick();
    req0_op = 4'd5; req0_pw = 3'd0; req0_valid = 1;
    tick();
    req0_valid = 0;
    m_last = 1'b0;
    repeat (4) tick();
    check("busy5_valid", {63'd0, malu_valid}, 1);
    ctrl_flush = 1;
    tick();
    ctrl_flush = 0;
    check("kill_flush", {63'd0, malu_flush}, 1);
    check("kill_no_rsp", {62'd0, rsp_valid, malu_valid}, 0);
    tick();
    check("kill_idle", {62'd0, malu_flush, rsp_valid}, 0);
    req0_op = 4'd6; req0_pw = 3'd3;
    transact(1, 0, 2, 0, {$urandom, $urandom}, 0);
    req0_valid = 0;

    // Reset in the middle of an op: no flush, tie priority back to req0
    tick();
    req1_op = 4'd7; req1_pw = 3'd0; req1_valid = 1;
    tick();
    req1_valid = 0;
    check("pre_reset_busy", {63'd0, malu_valid}, 1);
    resetn = 0;
    tick();
    check("midrst_outputs", {61'd0, malu_valid, malu_flush, rsp_valid}, 0);
    check("midrst_uop", malu_uop, 0);
    resetn = 1;
    m_last = 1'b1;
    transact(1, 1, 1, 0, {$urandom, $urandom}, 0);
    req0_valid = 0; req1_valid = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 12; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      req0_op = 4'($urandom_range(0, 15)); req0_pw = 3'($urandom_range(0, 5));
      req1_op = 4'($urandom_range(0, 15)); req1_pw = 3'($urandom_range(0, 5));
      req0_rs1 = $urandom; req0_rs2 = $urandom; req0_rs3 = $urandom;
      req1_rs1 = $urandom; req1_rs2 = $urandom; req1_rs3 = $urandom;
      lat  = $urandom_range(1, 6);
      hold = $urandom_range(0, 2);
      transact(v0, v1, lat, hold, {$urandom, $urandom}, 0);
      req0_valid = 0; req1_valid = 0;
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
